// File: rtl/us_scan_scheduler.sv
// Round-robin HC-SR04 scan scheduler: triggers one sensor at a time, times its echo
// pulse and converts the width to millimetres with a per-channel presence flag.
//
// state     | meaning
// IDLE      | waiting for enable and a non-empty channel mask
// TRIG      | driving trig[cur_ch] for TRIG_CYC clocks
// WAIT_RISE | waiting for the selected echo to rise
// MEASURE   | counting echo high time
// GAP       | settling before the next channel may be triggered

module us_scan_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int TRIG_CYC     = 500,
    parameter int ECHO_TIMEOUT = 1000000,
    parameter int GAP_CYC      = 500000,
    parameter int THRESH_MM    = 500
) (
    input  logic        clk_50M,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  ch_mask,
    input  logic [3:0]  echo_rx,
    output logic [3:0]  trig,
    output logic        busy,
    output logic [1:0]  cur_ch,
    output logic        dist_valid,
    output logic [1:0]  dist_ch,
    output logic [15:0] dist_mm,
    output logic [3:0]  obj_present
);

    localparam int TW = 20;
    localparam logic [TW-1:0] TRIG_END = TW'(TRIG_CYC - 1);
    localparam logic [TW-1:0] ECHO_END = TW'(ECHO_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_END  = TW'(GAP_CYC - 1);
    localparam logic [15:0]   THRESH   = 16'(THRESH_MM);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic [3:0]      trig_nxt;
    logic [1:0]      cur_ch_nxt;
    logic [1:0]      last_ch, last_ch_nxt;
    logic [3:0]      echo_m, echo_s;
    logic [1:0]      next_ch, idx;
    logic            found, sel_ok, echo_cur;
    logic            res_dist, res_tmo;
    logic [24:0]     prod;
    logic [15:0]     dist_calc;

    assign busy      = (state != IDLE);
    assign echo_cur  = echo_s[cur_ch];
    assign sel_ok    = enable && (ch_mask != 4'b0000);
    // Full 25-bit product keeps the worst-case count*17 exact before dividing.
    assign prod      = timer * 25'd17;
    assign dist_calc = 16'(prod / 25'd5000);

    always_comb begin
        next_ch = last_ch;
        found   = 1'b0;
        idx     = last_ch;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = last_ch + 2'(i);
            if (!found && ch_mask[idx]) begin
                next_ch = idx;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        trig_nxt    = trig;
        cur_ch_nxt  = cur_ch;
        last_ch_nxt = last_ch;
        res_dist    = 1'b0;
        res_tmo     = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (state == GAP && timer != GAP_END) begin
                    timer_nxt = timer + 1'b1;
                end else if (sel_ok) begin
                    state_nxt   = TRIG;
                    timer_nxt   = '0;
                    cur_ch_nxt  = next_ch;
                    last_ch_nxt = next_ch;
                    trig_nxt    = 4'b0001 << next_ch;
                end else begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
            end
            TRIG: begin
                if (timer == TRIG_END) begin
                    state_nxt = WAIT_RISE;
                    timer_nxt = '0;
                    trig_nxt  = 4'b0000;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            WAIT_RISE: begin
                if (echo_cur) begin
                    state_nxt = MEASURE;
                    timer_nxt = TW'(1);
                end else if (timer == ECHO_END) begin
                    res_tmo   = 1'b1;
                    state_nxt = GAP;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            MEASURE: begin
                if (!echo_cur) begin
                    res_dist  = 1'b1;
                    state_nxt = GAP;
                    timer_nxt = '0;
                end else if (timer == ECHO_END) begin
                    res_tmo   = 1'b1;
                    state_nxt = GAP;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
                trig_nxt  = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            trig        <= 4'b0000;
            cur_ch      <= 2'd0;
            last_ch     <= 2'(NUM_CH - 1);
            echo_m      <= 4'b0000;
            echo_s      <= 4'b0000;
            dist_valid  <= 1'b0;
            dist_ch     <= 2'd0;
            dist_mm     <= 16'd0;
            obj_present <= 4'b0000;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            trig       <= trig_nxt;
            cur_ch     <= cur_ch_nxt;
            last_ch    <= last_ch_nxt;
            echo_m     <= echo_rx;
            echo_s     <= echo_m;
            dist_valid <= res_dist | res_tmo;
            if (res_dist) begin
                dist_ch             <= cur_ch;
                dist_mm             <= dist_calc;
                obj_present[cur_ch] <= (dist_calc <= THRESH);
            end else if (res_tmo) begin
                dist_ch             <= cur_ch;
                dist_mm             <= 16'hFFFF;
                obj_present[cur_ch] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_us_scan_scheduler.sv
// Bench for us_scan_scheduler with shortened timing parameters: table vectors,
// randomized scans against a reference model, and reset/enable/ordering sequences.

module tb_us_scan_scheduler;

    localparam int TRIG_CYC     = 20;
    localparam int ECHO_TIMEOUT = 8000;
    localparam int GAP_CYC      = 300;
    localparam int THRESH_MM    = 20;

    logic        clk_50M = 1'b0;
    logic        reset   = 1'b1;
    logic        enable  = 1'b0;
    logic [3:0]  ch_mask = 4'b0000;
    logic [3:0]  echo_rx = 4'b0000;
    logic [3:0]  trig;
    logic        busy;
    logic [1:0]  cur_ch;
    logic        dist_valid;
    logic [1:0]  dist_ch;
    logic [15:0] dist_mm;
    logic [3:0]  obj_present;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          rr_last = 3;
    logic [3:0]  obj_model = 4'b0000;

    typedef struct {
        int ch;
        int n;
        int mm;
        int obj;
    } vec_t;
    vec_t vecs[7];
    int   ord[4];

    us_scan_scheduler #(
        .NUM_CH(4), .TRIG_CYC(TRIG_CYC), .ECHO_TIMEOUT(ECHO_TIMEOUT),
        .GAP_CYC(GAP_CYC), .THRESH_MM(THRESH_MM)
    ) dut (
        .clk_50M(clk_50M), .reset(reset), .enable(enable), .ch_mask(ch_mask),
        .echo_rx(echo_rx), .trig(trig), .busy(busy), .cur_ch(cur_ch),
        .dist_valid(dist_valid), .dist_ch(dist_ch), .dist_mm(dist_mm),
        .obj_present(obj_present)
    );

    always #5 clk_50M = ~clk_50M;
    always @(posedge clk_50M) cyc <= cyc + 1;

    initial begin
        repeat (95000) @(posedge clk_50M);
        $display("FAIL watchdog: got %0d cycles, required finish earlier", cyc);
        $fatal(1, "bench did not complete");
    end

    task automatic check_eq(input string name, input int act, input int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, want);
        end
    endtask

    function automatic int next_ch(input logic [3:0] m);
        for (int k = 1; k <= 4; k++)
            if (m[(rr_last + k) % 4]) return (rr_last + k) % 4;
        return -1;
    endfunction

    function automatic int ref_mm(input int n);
        if (n <= 0 || n >= ECHO_TIMEOUT) return 65535;
        return (n * 17) / 5000;
    endfunction

    function automatic int ref_obj(input int n);
        int mm;
        mm = ref_mm(n);
        return (mm != 65535 && mm <= THRESH_MM) ? 1 : 0;
    endfunction

    task automatic check_reset_outputs(input string name);
        check_eq({name, "_trig"}, trig, 0);
        check_eq({name, "_busy"}, busy, 0);
        check_eq({name, "_cur_ch"}, cur_ch, 0);
        check_eq({name, "_dist_valid"}, dist_valid, 0);
        check_eq({name, "_dist_ch"}, dist_ch, 0);
        check_eq({name, "_dist_mm"}, dist_mm, 0);
        check_eq({name, "_obj"}, obj_present, 0);
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while (busy && w < 20000) begin
            @(negedge clk_50M);
            w++;
        end
        check_eq({name, "_idle"}, busy, 0);
    endtask

    // One full scan: n=0 means no echo (timeout); noise raises all other echo lines.
    task automatic do_meas(input int exp_ch, input int n, input int pre, input bit noise,
                           input int drop_at, input int exp_mm, input int exp_obj,
                           input string name, output int got_ch, output int rise);
        int w, hl, since;
        got_ch = -1;
        rise   = 0;
        w = 0;
        while (trig == 4'b0000 && w < 5000) begin
            @(negedge clk_50M);
            w++;
        end
        if (trig == 4'b0000) begin
            check_eq({name, "_trig_start"}, 0, 1);
            return;
        end
        rise = cyc;
        for (int k = 0; k < 4; k++)
            if (trig == (4'b0001 << k)) got_ch = k;
        check_eq({name, "_trig_ch"}, got_ch, exp_ch);
        check_eq({name, "_cur_ch"}, cur_ch, exp_ch);
        hl = 0;
        while (trig != 4'b0000 && hl < TRIG_CYC * 4) begin
            @(negedge clk_50M);
            hl++;
        end
        check_eq({name, "_trig_len"}, hl, TRIG_CYC);
        since = 0;
        if (noise) echo_rx = ~(4'b0001 << exp_ch);
        for (int i = 0; i < pre; i++) begin
            @(negedge clk_50M);
            since++;
        end
        if (n > 0) begin
            echo_rx[exp_ch] = 1'b1;
            for (int i = 0; i < n; i++) begin
                if (i == drop_at) begin
                    enable  = 1'b0;
                    ch_mask = 4'b0000;
                end
                @(negedge clk_50M);
                since++;
            end
            echo_rx[exp_ch] = 1'b0;
        end
        w = 0;
        while (!dist_valid && w < ECHO_TIMEOUT + 100) begin
            @(negedge clk_50M);
            since++;
            w++;
        end
        if (!dist_valid) begin
            check_eq({name, "_result"}, 0, 1);
            echo_rx = 4'b0000;
            return;
        end
        check_eq({name, "_latency"}, since, (n > 0) ? pre + n + 3 : ECHO_TIMEOUT);
        check_eq({name, "_dist_ch"}, dist_ch, exp_ch);
        check_eq({name, "_dist_mm"}, dist_mm, exp_mm);
        obj_model[exp_ch] = exp_obj[0];
        check_eq({name, "_obj"}, obj_present, obj_model);
        echo_rx = 4'b0000;
        @(negedge clk_50M);
        check_eq({name, "_strobe_len"}, dist_valid, 0);
        check_eq({name, "_gap_busy"}, busy, 1);
        rr_last = exp_ch;
    endtask

    initial begin
        int gc, rs, prev_rise, cnt, w, ec, n;
        logic [3:0] m;

        vecs[0] = '{0, 6176, 20, 1};
        vecs[1] = '{1, 6177, 21, 0};
        vecs[2] = '{2, 3000, 10, 1};
        vecs[3] = '{3, 1, 0, 1};
        vecs[4] = '{0, 7000, 23, 0};
        vecs[5] = '{2, 0, 65535, 0};
        vecs[6] = '{1, 500, 1, 1};
        ord = '{1, 3, 1, 3};

        repeat (3) @(negedge clk_50M);
        check_reset_outputs("reset");
        reset = 1'b0;

        enable  = 1'b1;
        ch_mask = 4'b0000;
        repeat (20) @(negedge clk_50M);
        check_eq("idle_no_mask_busy", busy, 0);
        check_eq("idle_no_mask_trig", trig, 0);
        enable  = 1'b0;
        ch_mask = 4'b1111;
        repeat (20) @(negedge clk_50M);
        check_eq("idle_disabled_busy", busy, 0);

        for (int i = 0; i < 7; i++) begin
            wait_idle($sformatf("vec%0d", i));
            ch_mask = 4'b0001 << vecs[i].ch;
            enable  = 1'b1;
            do_meas(vecs[i].ch, vecs[i].n, 4 + i, 1'b0, -1, vecs[i].mm, vecs[i].obj,
                    $sformatf("vec%0d", i), gc, rs);
            enable = 1'b0;
        end

        for (int i = 0; i < 6; i++) begin
            wait_idle($sformatf("rnd%0d", i));
            m       = 4'($urandom_range(1, 15));
            ch_mask = m;
            ec      = next_ch(m);
            n       = $urandom_range(1, 2500);
            enable  = 1'b1;
            do_meas(ec, n, $urandom_range(0, 30), 1'b1, -1, ref_mm(n), ref_obj(n),
                    $sformatf("rnd%0d", i), gc, rs);
            enable = 1'b0;
        end

        wait_idle("drop");
        ch_mask = 4'b0100;
        enable  = 1'b1;
        do_meas(2, 400, 3, 1'b0, 100, 1, 1, "drop", gc, rs);
        cnt = 1;
        while (busy && cnt < GAP_CYC * 2) begin
            @(negedge clk_50M);
            cnt++;
        end
        check_eq("drop_gap_len", cnt, GAP_CYC);
        repeat (20) @(negedge clk_50M);
        check_eq("drop_idle_busy", busy, 0);
        check_eq("drop_idle_trig", trig, 0);

        wait_idle("rst");
        ch_mask = 4'b0110;
        ec      = next_ch(4'b0110);
        enable  = 1'b1;
        w = 0;
        while (trig == 4'b0000 && w < 5000) begin
            @(negedge clk_50M);
            w++;
        end
        check_eq("rst_pre_trig", trig, 4'b0001 << ec);
        repeat (5) @(negedge clk_50M);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk_50M);
        check_reset_outputs("rst_mid_trig");
        reset     = 1'b0;
        rr_last   = 3;
        obj_model = 4'b0000;
        @(negedge clk_50M);
        ch_mask = 4'b1111;
        enable  = 1'b1;
        do_meas(0, 600, 2, 1'b0, -1, 2, 1, "post_rst", gc, rs);
        enable = 1'b0;

        wait_idle("order");
        ch_mask   = 4'b1010;
        enable    = 1'b1;
        prev_rise = 0;
        for (int i = 0; i < 4; i++) begin
            do_meas(ord[i], 50, 2, 1'b1, -1, 0, 1, $sformatf("order%0d", i), gc, rs);
            if (i > 0)
                check_eq($sformatf("order%0d_spacing_ok", i),
                         (rs - prev_rise >= GAP_CYC) ? 1 : 0, 1);
            prev_rise = rs;
        end
        enable = 1'b0;
        wait_idle("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/us_scan_scheduler.md
US_SCAN_SCHEDULER -- requirements
Module: us_scan_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of HC-SR04 sensors scheduled (fixed at 4 for the port widths below).
REQ-002 SHALL have parameter TRIG_CYC, default 500, meaning trigger high time in clocks (10 us).
REQ-003 SHALL have parameter ECHO_TIMEOUT, default 1000000, meaning max clocks in WAIT_RISE or MEASURE before timeout (20 ms).
REQ-004 SHALL have parameter GAP_CYC, default 500000, meaning settle clocks between channel measurements (10 ms).
REQ-005 SHALL have parameter THRESH_MM, default 500, meaning object-present distance limit in mm.
REQ-006 SHALL have port clk_50M, input, 1 bit, meaning 50 MHz clock; single clock domain.
REQ-007 SHALL have port reset, input, 1 bit, meaning synchronous, active-high reset.
REQ-008 SHALL have port enable, input, 1 bit, meaning scanning permitted.
REQ-009 SHALL have port ch_mask, input, 4 bits, meaning per-channel scan enable.
REQ-010 SHALL have port echo_rx, input, 4 bits, meaning asynchronous echo lines, one per sensor.
REQ-011 SHALL have port trig, output, 4 bits, meaning registered trigger lines, one per sensor.
REQ-012 SHALL have port busy, output, 1 bit, meaning high in any state other than IDLE.
REQ-013 SHALL have port cur_ch, output, 2 bits, meaning channel currently owned by the sequencer.
REQ-014 SHALL have port dist_valid, output, 1 bit, meaning one-cycle result strobe.
REQ-015 SHALL have port dist_ch, output, 2 bits, meaning channel of the latched result.
REQ-016 SHALL have port dist_mm, output, 16 bits, meaning latched distance in mm.
REQ-017 SHALL have port obj_present, output, 4 bits, meaning per-channel object flag.

Function
REQ-018 SHALL pass each echo_rx bit through a 2-flop synchronizer; all echo decisions SHALL use the synchronized value echo_s.
REQ-019 SHALL implement FSM states IDLE, TRIG, WAIT_RISE, MEASURE and GAP with a single 20-bit timer.
REQ-020 IDLE: when enable=1 and ch_mask!=0, SHALL select the next channel and go to TRIG with timer=0; otherwise SHALL stay in IDLE.
REQ-021 Channel selection SHALL be round-robin: the first set ch_mask bit strictly after the last measured channel, wrapping 3->0; after reset the search SHALL start at channel 0.
REQ-022 TRIG: trig[cur_ch] SHALL be high for exactly TRIG_CYC clocks with all other trig bits 0, then the FSM SHALL go to WAIT_RISE with timer cleared.
REQ-023 WAIT_RISE: echo_s[cur_ch]=1 SHALL move the FSM to MEASURE with echo count=1; timer reaching ECHO_TIMEOUT SHALL produce a timeout result.
REQ-024 MEASURE: SHALL count clocks while echo_s[cur_ch]=1; echo_s low SHALL produce a distance result; count reaching ECHO_TIMEOUT SHALL produce a timeout result.
REQ-025 Distance SHALL be computed as dist_mm = floor(count*17/5000), using a product of at least 25 bits and no truncation before the divide.
REQ-026 On a result, the clock edge that leaves WAIT_RISE/MEASURE SHALL load dist_ch=cur_ch and dist_mm, set dist_valid high for exactly one cycle, and enter GAP.
REQ-027 On a distance result, obj_present[cur_ch] SHALL be set to (dist_mm<=THRESH_MM); only that bit SHALL change.
REQ-028 A timeout result SHALL load dist_mm=16'hFFFF and clear obj_present[cur_ch].
REQ-029 GAP: after GAP_CYC clocks the FSM SHALL behave as IDLE (select next channel or go to IDLE), ensuring no two triggers are closer than GAP_CYC clocks.
REQ-030 Deasserting enable or changing ch_mask mid-measurement SHALL NOT abort the current channel; both SHALL be sampled only at selection time.
REQ-031 Echo activity on non-selected channels SHALL be ignored.

Reset
REQ-032 On reset=1 at a clock edge, SHALL set state=IDLE, trig=0, busy=0, cur_ch=0, dist_valid=0, dist_ch=0, dist_mm=0, obj_present=0, timer=0, synchronizers=0, and the round-robin pointer so that channel 0 is searched first.
REQ-033 Reset asserted mid-TRIG SHALL drop trig on the same edge.

Verification
REQ-034 With ch_mask=4'b0001 and enable=1, echo0 high for 58824 clocks, the bench SHALL check: trig[0] high for 500 clocks, then dist_valid with dist_ch=0, dist_mm=200, obj_present[0]=1.
REQ-035 With echo high for 147059 clocks the bench SHALL check dist_mm=500 and obj_present=1; with 147353 clocks it SHALL check dist_mm=501 and obj_present=0.
REQ-036 With no echo, the bench SHALL check dist_valid 1000000 clocks after WAIT_RISE entry with dist_mm=16'hFFFF and obj_present[ch]=0.
REQ-037 With ch_mask=4'b1010, the bench SHALL check a trigger order of 1,3,1,3 and that successive trigger rising edges are at least GAP_CYC clocks apart.
REQ-038 With enable dropped during MEASURE, the bench SHALL check that the result is still delivered, followed by GAP and then IDLE with busy=0.
REQ-039 With reset pulsed during TRIG, the bench SHALL check trig=0 next cycle, all outputs at reset values, and that the next scan starts at channel 0.
